// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes and the highest legal code.
// Imported by the ALU, the arbiter and its handshake interface.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

    // Codes above this value are undefined and flagged as illegal.
    localparam logic [3:0] ALU_OP_MAX = OP_SRA;

endpackage

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the consumer.
// master: requesters + consumer side; slave: the arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
);

    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_zero;
    logic             res_illegal;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_zero, res_illegal,
        input  res_id, res_tag
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_zero, res_illegal,
        output res_id, res_tag
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. Ports: input1/input2 operands, ALUControl op code,
// ALUResult result, zero set when the result is 0. Undefined codes yield 0.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] input1,
    input  logic [31:0] input2,
    input  logic [3:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic        zero
);

    logic [4:0] shamt;

    assign shamt = input2[4:0];

    always_comb begin
        ALUResult = 32'h0;
        unique case (ALUControl)
            OP_AND:  ALUResult = input1 & input2;
            OP_OR:   ALUResult = input1 | input2;
            OP_ADD:  ALUResult = input1 + input2;
            OP_SUB:  ALUResult = input1 - input2;
            OP_XOR:  ALUResult = input1 ^ input2;
            OP_SLT:  ALUResult = {31'h0, input1 < input2};
            OP_SLL:  ALUResult = input1 << shamt;
            OP_SRL:  ALUResult = input1 >> shamt;
            OP_SRA:  ALUResult = $signed(input1) >>> shamt;
            default: ALUResult = 32'h0;
        endcase
    end

    assign zero = (ALUResult == 32'h0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Ports: clk, reset_n (sync, active-low), bus (slave side of alu_arbiter_if).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);

    logic             last_grant;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             xfer;
    logic [3:0]       op_sel;
    logic [31:0]      a_sel;
    logic [31:0]      b_sel;
    logic [TAG_W-1:0] tag_sel;
    logic [31:0]      alu_res;
    logic             alu_zero;

    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_zero;
    logic             res_illegal;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;

    // The result register may drain and refill in the same cycle.
    assign can_accept = !res_valid || bus.res_ready;

    // On contention the requester that did not win last time is granted.
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = grant0 && can_accept && reset_n;
    assign bus.req1_ready = grant1 && can_accept && reset_n;

    assign xfer = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);

    assign op_sel  = grant1 ? bus.req1_op  : bus.req0_op;
    assign a_sel   = grant1 ? bus.req1_a   : bus.req0_a;
    assign b_sel   = grant1 ? bus.req1_b   : bus.req0_b;
    assign tag_sel = grant1 ? bus.req1_tag : bus.req0_tag;

    alu_arbiter_alu u_alu (
        .input1     (a_sel),
        .input2     (b_sel),
        .ALUControl (op_sel),
        .ALUResult  (alu_res),
        .zero       (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_valid   <= 1'b0;
            res_data    <= 32'h0;
            res_zero    <= 1'b0;
            res_illegal <= 1'b0;
            res_id      <= 1'b0;
            res_tag     <= '0;
            last_grant  <= 1'b1;
        end else if (xfer) begin
            res_valid   <= 1'b1;
            res_data    <= alu_res;
            res_zero    <= alu_zero;
            res_illegal <= (op_sel > ALU_OP_MAX);
            res_id      <= grant1;
            res_tag     <= tag_sel;
            last_grant  <= grant1;
        end else if (bus.res_ready) begin
            res_valid   <= 1'b0;
        end
    end

    assign bus.res_valid   = res_valid;
    assign bus.res_data    = res_data;
    assign bus.res_zero    = res_zero;
    assign bus.res_illegal = res_illegal;
    assign bus.res_id      = res_id;
    assign bus.res_tag     = res_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal values
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_arbiter;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

    alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural model state
    bit               started = 0;
    logic             m_valid;
    logic [31:0]      m_data;
    logic             m_zero;
    logic             m_illegal;
    logic             m_id;
    logic [TAG_W-1:0] m_tag;
    logic             m_last;
    logic             m_x0 = 0;
    logic             m_x1 = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a,
                                            logic [31:0] b);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return a ^ b;
            4'd5: return (a < b) ? 32'd1 : 32'd0;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            4'd8: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // Which requester the rules say may transfer right now.
    function automatic void exp_ready(output logic r0, output logic r1);
        logic room;
        room = !m_valid || bus.res_ready;
        r0 = 1'b0;
        r1 = 1'b0;
        if (reset_n && room) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (m_last) r0 = 1'b1;
                else        r1 = 1'b1;
            end else if (bus.req0_valid) r0 = 1'b1;
            else if (bus.req1_valid)     r1 = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        logic r0, r1;
        started = 1;
        exp_ready(r0, r1);
        m_x0 = bus.req0_valid && r0;
        m_x1 = bus.req1_valid && r1;
        if (!reset_n) begin
            m_valid = 0; m_data = 0; m_zero = 0; m_illegal = 0;
            m_id = 0; m_tag = 0; m_last = 1;
        end else if (m_x0 || m_x1) begin
            m_valid   = 1;
            m_id      = m_x1;
            m_last    = m_x1;
            m_data    = m_x1 ? ref_alu(bus.req1_op, bus.req1_a, bus.req1_b)
                             : ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
            m_zero    = (m_data == 0);
            m_illegal = m_x1 ? (bus.req1_op > 8) : (bus.req0_op > 8);
            m_tag     = m_x1 ? bus.req1_tag : bus.req0_tag;
        end else if (bus.res_ready) begin
            m_valid = 0;
        end
    end

    // Compare process
    always @(negedge clk) begin
        logic r0, r1;
        if (started) begin
            exp_ready(r0, r1);
            chk("m_ready0", 32'(bus.req0_ready), 32'(r0));
            chk("m_ready1", 32'(bus.req1_ready), 32'(r1));
            chk("m_valid", 32'(bus.res_valid), 32'(m_valid));
            chk("m_data", bus.res_data, m_data);
            chk("m_zero", 32'(bus.res_zero), 32'(m_zero));
            chk("m_illegal", 32'(bus.res_illegal), 32'(m_illegal));
            chk("m_id", 32'(bus.res_id), 32'(m_id));
            chk("m_tag", 32'(bus.res_tag), 32'(m_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(logic v, logic [3:0] op, logic [31:0] a,
                        logic [31:0] b, logic [TAG_W-1:0] t);
        bus.req0_valid = v; bus.req0_op = op;
        bus.req0_a = a; bus.req0_b = b; bus.req0_tag = t;
    endtask

    task automatic set1(logic v, logic [3:0] op, logic [31:0] a,
                        logic [31:0] b, logic [TAG_W-1:0] t);
        bus.req1_valid = v; bus.req1_op = op;
        bus.req1_a = a; bus.req1_b = b; bus.req1_tag = t;
    endtask

    task automatic res_chk(string nm, logic v, logic [31:0] d, logic z,
                           logic il, logic id, logic [TAG_W-1:0] t);
        chk({nm, "_valid"}, 32'(bus.res_valid), 32'(v));
        chk({nm, "_data"}, bus.res_data, d);
        chk({nm, "_zero"}, 32'(bus.res_zero), 32'(z));
        chk({nm, "_illegal"}, 32'(bus.res_illegal), 32'(il));
        chk({nm, "_id"}, 32'(bus.res_id), 32'(id));
        chk({nm, "_tag"}, 32'(bus.res_tag), 32'(t));
    endtask

    initial begin
        reset_n = 0;
        bus.res_ready = 1;
        set0(1, 4'b0011, 32'd5, 32'd5, 4'hA);
        set1(1, 4'b1000, 32'h8000_0000, 32'd4, 4'hB);

        // Reset with both requesters valid
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            res_chk("rst", 0, 32'h0, 0, 0, 0, 4'h0);
            tick();
        end
        reset_n = 1;

        // Contention: grants alternate starting with requester 0
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_ready0", 32'(bus.req0_ready), 32'(k % 2 == 0));
            chk("cont_ready1", 32'(bus.req1_ready), 32'(k % 2 == 1));
            if (k % 2 == 1) res_chk("cont_r0", 1, 32'h0, 1, 0, 0, 4'hA);
            if (k == 2) res_chk("cont_r1", 1, 32'hF800_0000, 0, 0, 1, 4'hB);
            tick();
        end

        // Single requester ADD with wrap
        set0(1, 4'b0010, 32'hFFFF_FFFF, 32'd2, 4'h3);
        set1(0, 4'b0000, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        res_chk("cont_last", 1, 32'hF800_0000, 0, 0, 1, 4'hB);
        chk("single_ready0", 32'(bus.req0_ready), 32'd1);
        tick();

        // Back-pressure: result held, req1 waits
        set0(0, 4'b0000, 32'h0, 32'h0, 4'h0);
        set1(1, 4'b0100, 32'h0000_00F0, 32'h0000_000F, 4'h5);
        bus.res_ready = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
            res_chk("single", 1, 32'h1, 0, 0, 0, 4'h3);
            tick();
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("bp_refill_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(0, 4'b0000, 32'h0, 32'h0, 4'h0);
        set0(1, 4'b1011, 32'h1234, 32'h5678, 4'h1);
        @(negedge clk);
        res_chk("bp_result", 1, 32'h0000_00FF, 0, 0, 1, 4'h5);
        tick();

        // Illegal op, then unsigned SLT
        set0(1, 4'b0101, 32'h1, 32'hFFFF_FFFF, 4'h2);
        @(negedge clk);
        res_chk("illegal", 1, 32'h0, 1, 1, 0, 4'h1);
        tick();
        set0(1, 4'b0001, 32'h12, 32'h0, 4'h7);
        @(negedge clk);
        res_chk("slt", 1, 32'h1, 0, 0, 0, 4'h2);
        tick();

        // Reset while a result is held
        set0(0, 4'b0000, 32'h0, 32'h0, 4'h0);
        bus.res_ready = 0;
        @(negedge clk);
        res_chk("held", 1, 32'h12, 0, 0, 0, 4'h7);
        tick();
        reset_n = 0;
        @(negedge clk);
        tick();
        reset_n = 1;
        @(negedge clk);
        res_chk("midrst", 0, 32'h0, 0, 0, 0, 4'h0);
        tick();
        bus.res_ready = 1;
        @(negedge clk);
        chk("midrst_gone", 32'(bus.res_valid), 32'd0);
        tick();

        // Randomized traffic; unaccepted requests are held stable
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            if (!bus.req0_valid || m_x0) begin
                a = $urandom;
                set0(($urandom % 4) != 0, 4'($urandom_range(0, 10)), a,
                     (($urandom % 4) == 0) ? a : $urandom, 4'($urandom));
            end
            if (!bus.req1_valid || m_x1) begin
                a = $urandom;
                set1(($urandom % 4) != 0, 4'($urandom_range(0, 10)), a,
                     (($urandom % 4) == 0) ? a : $urandom, 4'($urandom));
            end
            bus.res_ready = ($urandom % 4) != 0;
            tick();
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters (e.g. integer pipe and address/branch unit) using valid/ready handshakes.
- Round-robin grant; the selected operation executes through one ALU instance.
- Result, zero flag, requester id and tag are captured in a one-entry output register, giving 1-cycle latency and full throughput.
- Sits between the issue logic and writeback/consumer logic.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to result.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  reset, synchronous, active-low
req0_valid  in  1  requester 0 presents an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  4  ALU control code
req0_a  in  32  operand 1
req0_b  in  32  operand 2
req0_tag  in  TAG_W  opaque tag
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag  same as requester 0, for requester 1
res_valid  out  1  result register holds a valid result
res_ready  in  1  consumer accepts the result
res_data  out  32  ALU result
res_zero  out  1  result == 0
res_illegal  out  1  op code was not a defined code (0x9–0xF)
res_id  out  1  index of the requester that issued the operation
res_tag  out  TAG_W  tag of the issuing requester

Behaviour:
- Reset: when reset_n == 0 at a rising edge:
  - res_valid, res_data, res_zero, res_illegal, res_id, res_tag all become 0.
  - last_grant becomes 1, so requester 0 wins the first contention.
  - req0_ready/req1_ready are 0 in any cycle where reset_n == 0.
- Acceptance capacity: can_accept = !res_valid || res_ready (pipelined; the result register may drain and refill in the same cycle).
- Grant (combinational):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
- Ready: reqN_ready = grantN && can_accept && reset_n. The other requester's ready is 0.
- Transfer: a transfer occurs when reqN_valid && reqN_ready. On that edge:
  - res_data and res_zero take the ALU outputs for the granted op/a/b.
  - res_illegal = (op > 4'b1000); res_id = N; res_tag = tagN; res_valid = 1.
  - last_grant = N.
- No transfer, and res_valid && res_ready: res_valid = 0. The data fields hold their values (don't-care).
- No transfer, and !res_ready: the result register and last_grant hold.
- ALU codes (these exact codes are used):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR.
  - 0101 SLT: unsigned compare, result 1 or 0.
  - 0110 SLL, 0111 SRL, 1000 SRA; shift amount is b[4:0].
  - Other codes: result 0, zero = 1, res_illegal = 1.
- Arithmetic: ADD/SUB wrap modulo 2^32; no carry or overflow output.
- Requester obligations: hold op/a/b/tag stable while valid && !ready. The arbiter does not buffer unaccepted requests.
- Fairness: under continuous contention with res_ready = 1, grants alternate 0,1,0,1…; neither requester waits more than one transfer.
- Back-pressure: res_ready held low causes at most one result to be held, and both readys are 0 until it drains.
- Reset mid-operation: a held result is discarded, and in-flight requests must be re-presented after reset.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU op code constants (AND…SRA);
  - the ALU_OP_MAX = 4'b1000 constant used for res_illegal.
- One sub-module: the existing ALU, instantiated once with its ports input1/input2/ALUControl/ALUResult/zero. The arbiter adds no arithmetic of its own.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with both valid = 1 -> readys = 0, res_valid = 0, all result outputs 0. After release, first contention is granted to requester 0.
- Single requester: req0 op = 0010, a = 0xFFFFFFFF, b = 0x00000002, tag = 0x3, res_ready = 1 -> next cycle res_valid = 1, res_data = 0x00000001, res_zero = 0, res_id = 0, res_tag = 0x3.
- Contention: both valid, 4 cycles, res_ready = 1, req0 op = 0011 a = 5 b = 5; req1 op = 1000 a = 0x80000000 b = 4 ->
  - grant order 0,1,0,1;
  - results alternate res_data = 0, res_zero = 1 (req0) and res_data = 0xF8000000 (req1).
- Back-pressure: result pending, res_ready = 0 for 3 cycles with req1 valid -> req1_ready = 0 and the result is stable. In the cycle res_ready rises, req1 is accepted the same cycle (drain + refill) and its result appears next cycle.
- Illegal and SLT: req0 op = 1011 -> res_data = 0, res_zero = 1, res_illegal = 1. Then op = 0101, a = 0x00000001, b = 0xFFFFFFFF -> res_data = 1, res_illegal = 0.
- Reset mid-operation: result held with res_ready = 0, then reset_n = 0 for 1 cycle -> res_valid = 0 the next cycle and the held result is never presented.
